// File: rtl/renkon_pkg.sv
// rtl/renkon_pkg.sv - shared widths, FSM state type and helpers for the pooling stage
// Purpose: common definitions imported by pool_max, pool_max_row and pool_max_if.
//   DWIDTH  : signed pixel width
//   LWIDTH  : width of size/position counters
//   pool_state_t : S_IDLE / S_RUN / S_FLUSH
//   dmin()  : most negative DWIDTH value, used as the identity for masked max
package renkon_pkg;

  localparam int DWIDTH = 16;
  localparam int LWIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } pool_state_t;

  function automatic logic signed [DWIDTH-1:0] dmin();
    dmin = {1'b1, {(DWIDTH-1){1'b0}}};
  endfunction

endpackage

// File: rtl/pool_max_if.sv
// rtl/pool_max_if.sv - window-in / pooled-value-out bus of the pooling stage
// Purpose: groups the data path handshake of pool_max.
//   in_valid    : pixel_in holds a valid window this cycle
//   pixel_in    : MAXLINE*MAXLINE signed elements, element (i,j) at index MAXLINE*i+j
//   out_valid   : pool_output valid this cycle
//   pool_output : signed pooled value
// Modports: master = window producer, slave = pool_max.
interface pool_max_if #(
  parameter int MAXLINE = 5
) ();
  import renkon_pkg::*;

  logic                                 in_valid;
  logic [MAXLINE*MAXLINE*DWIDTH-1:0]    pixel_in;
  logic                                 out_valid;
  logic signed [DWIDTH-1:0]             pool_output;

  modport master (
    output in_valid,
    output pixel_in,
    input  out_valid,
    input  pool_output
  );

  modport slave (
    input  in_valid,
    input  pixel_in,
    output out_valid,
    output pool_output
  );

endinterface

// File: rtl/pool_max_row.sv
// rtl/pool_max_row.sv - registered masked max of one window row
// Purpose: max over columns j < pool_size of one window row, captured when en is high.
//   clk, rst  : clock, synchronous active-high reset
//   en        : capture enable
//   row       : MAXLINE signed elements, element j at [j*DWIDTH +: DWIDTH], j=0 leftmost
//   pool_size : number of leading columns that take part
//   max_q     : registered masked max
module pool_max_row
  import renkon_pkg::*;
#(
  parameter int MAXLINE = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [MAXLINE*DWIDTH-1:0]   row,
  input  logic [LWIDTH-1:0]           pool_size,
  output logic signed [DWIDTH-1:0]    max_q
);

  logic signed [DWIDTH-1:0] max_d;

  // Columns outside the pool are replaced by the most negative value so they
  // can never win the comparison.
  always_comb begin
    max_d = dmin();
    for (int j = 0; j < MAXLINE; j++) begin
      if ((LWIDTH'(j) < pool_size) &&
          ($signed(row[j*DWIDTH +: DWIDTH]) > max_d)) begin
        max_d = $signed(row[j*DWIDTH +: DWIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else if (en) begin
      max_q <= max_d;
    end
  end

endmodule

// File: rtl/pool_max.sv
// rtl/pool_max.sv - non-overlapping max-pooling stage after the line buffer
// Purpose: takes one MAXLINE x MAXLINE window per accepted cycle in raster order over an
//   img_size x img_size plane and emits the max of the top-left pool_size x pool_size
//   sub-window at stride pool_size. Partial pools at the right/bottom edges are dropped.
//   Fixed latency of 3 cycles from in_valid to out_valid.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pool_en     : start-of-frame pulse, latches img_size and pool_size (ignored unless idle)
//   img_size    : plane edge in window positions
//   pool_size   : pool edge 1..MAXLINE, also the stride
//   bus         : pool_max_if slave (in_valid, pixel_in, out_valid, pool_output)
//   busy        : high whenever the FSM is not idle
//   frame_end   : one-cycle pulse on the last flush cycle
// Configuration: define POOL_MAX_RELU_EN to clamp negative results to zero in the
//   output register (fused ReLU, latency unchanged).
module pool_max
  import renkon_pkg::*;
#(
  parameter int MAXLINE = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pool_en,
  input  logic [LWIDTH-1:0]  img_size,
  input  logic [LWIDTH-1:0]  pool_size,
  pool_max_if.slave          bus,
  output logic               busy,
  output logic               frame_end
);

  localparam int LATENCY = 3;
  localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

  pool_state_t       state;
  logic [LWIDTH-1:0] r_img;
  logic [LWIDTH-1:0] r_pool;
  logic [LWIDTH-1:0] r_col;
  logic [LWIDTH-1:0] r_row;
  logic [LWIDTH-1:0] r_cph;
  logic [LWIDTH-1:0] r_rph;
  logic [1:0]        r_flush;

  logic accept;
  logic emit;
  logic last_col;
  logic last_row;

  assign accept   = bus.in_valid && (state == S_RUN);
  assign emit     = accept && (r_cph == r_pool - ONE) && (r_rph == r_pool - ONE);
  assign last_col = (r_col == r_img - ONE);
  assign last_row = (r_row == r_img - ONE);

  // Control FSM with position/phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      r_img     <= '0;
      r_pool    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_cph     <= '0;
      r_rph     <= '0;
      r_flush   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pool_en) begin
            r_img   <= img_size;
            r_pool  <= pool_size;
            r_col   <= '0;
            r_row   <= '0;
            r_cph   <= '0;
            r_rph   <= '0;
            r_flush <= '0;
            state   <= S_RUN;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (last_col) begin
              r_col <= '0;
              r_cph <= '0;
              r_rph <= (r_rph == r_pool - ONE) ? '0 : r_rph + ONE;
              if (last_row) begin
                r_row   <= '0;
                r_flush <= '0;
                state   <= S_FLUSH;
              end else begin
                r_row <= r_row + ONE;
              end
            end else begin
              r_col <= r_col + ONE;
              r_cph <= (r_cph == r_pool - ONE) ? '0 : r_cph + ONE;
            end
          end
        end
        S_FLUSH: begin
          // Three flush cycles so the last window drains; frame_end is raised
          // one cycle ahead so the registered pulse lands on the final cycle.
          r_flush <= r_flush + 2'd1;
          if (frame_end) begin
            frame_end <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (r_flush == 2'(LATENCY - 2)) begin
            frame_end <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          frame_end <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: per-row masked max, captured only for emitting windows.
  logic signed [DWIDTH-1:0] row_max [MAXLINE];
  logic                     v1;

  for (genvar i = 0; i < MAXLINE; i++) begin : g_row
    pool_max_row #(
      .MAXLINE (MAXLINE)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .en        (emit),
      .row       (bus.pixel_in[i*MAXLINE*DWIDTH +: MAXLINE*DWIDTH]),
      .pool_size (r_pool),
      .max_q     (row_max[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= emit;
    end
  end

  // Stage 2: masked max over the leading pool_size rows.
  logic signed [DWIDTH-1:0] m2;
  logic signed [DWIDTH-1:0] s2;
  logic                     v2;

  always_comb begin
    m2 = dmin();
    for (int i = 0; i < MAXLINE; i++) begin
      if ((LWIDTH'(i) < r_pool) && (row_max[i] > m2)) begin
        m2 = row_max[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2 <= m2;
      end
    end
  end

  // Stage 3: output register, optionally clamping negatives.
  logic signed [DWIDTH-1:0] s3_d;

  always_comb begin
`ifdef POOL_MAX_RELU_EN
    s3_d = s2[DWIDTH-1] ? '0 : s2;
`else
    s3_d = s2;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.pool_output <= '0;
    end else begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.pool_output <= s3_d;
      end
    end
  end

endmodule
